// File: rtl/v_sram_op2_seq.sv
// Burst sequencer for the dual-port 48-bit operand SRAM: paired-word write/read bursts, 2-deep read buffer.
// Optional macro V_SRAM_SEQ_WRAP_EN: burst addresses wrap modulo 2^ADDR_W instead of rejecting overrange commands.
module v_sram_op2_seq #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 48,
  parameter int LEN_W  = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic [DATA_W-1:0] wr_data2,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_waddr1,
  output logic [ADDR_W-1:0] sram_waddr2,
  output logic [DATA_W-1:0] sram_wdata1,
  output logic [DATA_W-1:0] sram_wdata2,
  output logic [ADDR_W-1:0] sram_raddr1,
  output logic [ADDR_W-1:0] sram_raddr2,
  input  logic [DATA_W-1:0] sram_rdata1,
  input  logic [DATA_W-1:0] sram_rdata2,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   ptr_r;
  logic [LEN_W-1:0]    wr_rem_r;
  logic [LEN_W-1:0]    iss_rem_r;
  logic [LEN_W-1:0]    pop_rem_r;
  logic                inflight_r;
  logic [1:0]          cnt_r;
  logic                fifo_wp_r;
  logic                fifo_rp_r;
  logic [2*DATA_W-1:0] fifo_r [2];
  logic                done_r;
  logic                err_r;

  logic                cmd_fire_s;
  logic                cmd_bad_s;
  logic                start_wr_s;
  logic                start_rd_s;
  logic                done_set_s;
  logic                err_set_s;
  logic                wr_fire_s;
  logic                pop_s;
  logic                issue_s;
  logic [1:0]          outstanding_s;

`ifdef V_SRAM_SEQ_WRAP_EN
  assign cmd_bad_s = cmd_base[0];
`else
  localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;
  logic [SUM_W-1:0] cmd_end_s;
  // A burst ending exactly at the top of the array is legal; one word further is not.
  assign cmd_end_s = SUM_W'(cmd_base) + (SUM_W'(cmd_len) << 1);
  assign cmd_bad_s = cmd_base[0] || (cmd_end_s > (SUM_W'(1'b1) << ADDR_W));
`endif

  assign cmd_ready     = (state_r == ST_IDLE) && !reset;
  assign cmd_fire_s    = cmd_valid && cmd_ready;
  assign wr_ready      = (state_r == ST_WRITE) && (wr_rem_r != {LEN_W{1'b0}});
  assign wr_fire_s     = wr_valid && wr_ready;
  assign rd_valid      = (cnt_r != 2'd0);
  assign pop_s         = rd_valid && rd_ready;
  assign outstanding_s = {1'b0, inflight_r} + cnt_r - {1'b0, pop_s};
  assign issue_s       = (state_r == ST_READ) && (iss_rem_r != {LEN_W{1'b0}}) &&
                         (outstanding_s < 2'd2);
  assign {rd_data1, rd_data2} = fifo_r[fifo_rp_r];
  assign busy          = (state_r != ST_IDLE);
  assign done          = done_r;
  assign err           = err_r;

  // Next-state and burst start/finish decisions.
  always_comb begin
    state_s    = state_r;
    start_wr_s = 1'b0;
    start_rd_s = 1'b0;
    done_set_s = 1'b0;
    err_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!cmd_fire_s) begin
          state_s = ST_IDLE;
        end else if (cmd_bad_s) begin
          err_set_s = 1'b1;
        end else if (cmd_len == {LEN_W{1'b0}}) begin
          done_set_s = 1'b1;
        end else if (cmd_write) begin
          state_s    = ST_WRITE;
          start_wr_s = 1'b1;
        end else begin
          state_s    = ST_READ;
          start_rd_s = 1'b1;
        end
      end
      ST_WRITE: begin
        if (wr_rem_r == {LEN_W{1'b0}}) begin
          state_s    = ST_IDLE;
          done_set_s = 1'b1;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (pop_s && (pop_rem_r == LEN_W'(1'b1))) begin
          state_s    = ST_IDLE;
          done_set_s = 1'b1;
        end else begin
          state_s = ST_READ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and status pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= done_set_s;
      err_r   <= err_set_s;
    end
  end

  // Address pointer and burst counters; pair 0 of a read is issued on the accept edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r     <= {ADDR_W{1'b0}};
      wr_rem_r  <= {LEN_W{1'b0}};
      iss_rem_r <= {LEN_W{1'b0}};
      pop_rem_r <= {LEN_W{1'b0}};
    end else if (start_wr_s) begin
      ptr_r    <= cmd_base;
      wr_rem_r <= cmd_len;
    end else if (start_rd_s) begin
      ptr_r     <= cmd_base + ADDR_W'(2'd2);
      iss_rem_r <= cmd_len - LEN_W'(1'b1);
      pop_rem_r <= cmd_len;
    end else begin
      if (wr_fire_s || issue_s) ptr_r <= ptr_r + ADDR_W'(2'd2);
      if (wr_fire_s) wr_rem_r <= wr_rem_r - LEN_W'(1'b1);
      if (issue_s) iss_rem_r <= iss_rem_r - LEN_W'(1'b1);
      if (pop_s) pop_rem_r <= pop_rem_r - LEN_W'(1'b1);
    end
  end

  // Registered SRAM write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sram_we     <= 1'b0;
      sram_waddr1 <= {ADDR_W{1'b0}};
      sram_waddr2 <= {ADDR_W{1'b0}};
      sram_wdata1 <= {DATA_W{1'b0}};
      sram_wdata2 <= {DATA_W{1'b0}};
    end else begin
      sram_we <= wr_fire_s;
      if (wr_fire_s) begin
        sram_waddr1 <= ptr_r;
        sram_waddr2 <= ptr_r + ADDR_W'(1'b1);
        sram_wdata1 <= wr_data1;
        sram_wdata2 <= wr_data2;
      end
    end
  end

  // Read address issue and the 2-entry capture FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sram_raddr1 <= {ADDR_W{1'b0}};
      sram_raddr2 <= {ADDR_W{1'b0}};
      inflight_r  <= 1'b0;
      cnt_r       <= 2'd0;
      fifo_wp_r   <= 1'b0;
      fifo_rp_r   <= 1'b0;
      fifo_r[0]   <= {(2*DATA_W){1'b0}};
      fifo_r[1]   <= {(2*DATA_W){1'b0}};
    end else begin
      if (start_rd_s) begin
        sram_raddr1 <= cmd_base;
        sram_raddr2 <= cmd_base + ADDR_W'(1'b1);
      end else if (issue_s) begin
        sram_raddr1 <= ptr_r;
        sram_raddr2 <= ptr_r + ADDR_W'(1'b1);
      end
      inflight_r <= start_rd_s || issue_s;
      if (inflight_r) begin
        fifo_r[fifo_wp_r] <= {sram_rdata1, sram_rdata2};
        fifo_wp_r         <= ~fifo_wp_r;
      end
      if (pop_s) fifo_rp_r <= ~fifo_rp_r;
      cnt_r <= cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

endmodule

// File: tb/tb_v_sram_op2_seq.sv
// Self-checking bench for v_sram_op2_seq: behavioural SRAM, reference memory and read/write scoreboards.
module tb_v_sram_op2_seq;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 48;
  localparam int LEN_W  = 9;
  localparam int WE_W   = 2*ADDR_W + 2*DATA_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data1, wr_data2;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data1, rd_data2;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_waddr1, sram_waddr2, sram_raddr1, sram_raddr2;
  logic [DATA_W-1:0] sram_wdata1, sram_wdata2, sram_rdata1, sram_rdata2;
  logic              busy, done, err;

  logic [DATA_W-1:0]   sram_mem [512];
  logic [DATA_W-1:0]   ref_mem  [512];
  logic [WE_W-1:0]     wq [$];
  logic [2*DATA_W-1:0] rq [$];
  int checks = 0;
  int errors = 0;

  v_sram_op2_seq dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data1(wr_data1), .wr_data2(wr_data2),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .sram_we(sram_we), .sram_waddr1(sram_waddr1), .sram_waddr2(sram_waddr2),
    .sram_wdata1(sram_wdata1), .sram_wdata2(sram_wdata2),
    .sram_raddr1(sram_raddr1), .sram_raddr2(sram_raddr2),
    .sram_rdata1(sram_rdata1), .sram_rdata2(sram_rdata2),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (sram_we) begin
      sram_mem[sram_waddr1] <= sram_wdata1;
      sram_mem[sram_waddr2] <= sram_wdata2;
    end
  end
  assign sram_rdata1 = sram_mem[sram_raddr1];
  assign sram_rdata2 = sram_mem[sram_raddr2];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready act=%b exp=0", cmd_ready); end
    checks++;
    if ({busy, done, err, rd_valid, wr_ready, sram_we} !== 6'b0) begin
      errors++; $display("FAIL reset_status act=%b exp=000000", {busy, done, err, rd_valid, wr_ready, sram_we});
    end
    checks++;
    if ({sram_waddr1, sram_waddr2, sram_raddr1, sram_raddr2} !== {(4*ADDR_W){1'b0}}) begin
      errors++; $display("FAIL reset_addr act=%h exp=0", {sram_waddr1, sram_waddr2, sram_raddr1, sram_raddr2});
    end
    checks++;
    if ({sram_wdata1, sram_wdata2, rd_data1, rd_data2} !== {(4*DATA_W){1'b0}}) begin
      errors++; $display("FAIL reset_data act=%h exp=0", {sram_wdata1, sram_wdata2, rd_data1, rd_data2});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release act=%b exp=1", cmd_ready); end
  endtask

  // Write burst; returns on the cycle done is observed.
  task automatic do_write(input logic [ADDR_W-1:0] base, input int len, input logic [DATA_W-1:0] seed);
    logic [ADDR_W-1:0] a, a1;
    logic [DATA_W-1:0] d1, d2;
    logic [WE_W-1:0] e;
    int sent = 0, seen = 0, cyc = 0, last_we = -10, done_cyc = -1;
    bit fin = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready act=%b exp=1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = base; cmd_len = LEN_W'(len);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy act=%b exp=1", busy); end
    a = base;
    while (!fin && cyc < 100) begin
      if (sram_we) begin
        checks++;
        if (wq.size() == 0) begin
          errors++; $display("FAIL wr_extra_commit addr=%h exp=none", sram_waddr1);
        end else begin
          e = wq.pop_front();
          if ({sram_waddr1, sram_waddr2, sram_wdata1, sram_wdata2} !== e) begin
            errors++; $display("FAIL wr_commit act=%h exp=%h", {sram_waddr1, sram_waddr2, sram_wdata1, sram_wdata2}, e);
          end
        end
        seen++;
        last_we = cyc;
      end
      if (done) begin
        fin = 1'b1;
        done_cyc = cyc;
      end else begin
        if (wr_ready && sent < len) begin
          d1 = seed + DATA_W'(2*sent);
          d2 = seed + DATA_W'(2*sent + 1);
          a1 = a + 9'd1;
          wr_valid = 1'b1; wr_data1 = d1; wr_data2 = d2;
          wq.push_back({a, a1, d1, d2});
          ref_mem[a] = d1;
          ref_mem[a1] = d2;
          a = a + 9'd2;
          sent++;
        end else begin
          wr_valid = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    wr_valid = 1'b0;
    checks++;
    if (!fin) begin errors++; $display("FAIL wr_timeout act=no_done exp=done"); end
    checks++;
    if (seen != len || wq.size() != 0) begin
      errors++; $display("FAIL wr_count act=%0d exp=%0d left=%0d", seen, len, wq.size());
    end
    checks++;
    if (done_cyc != last_we + 1) begin
      errors++; $display("FAIL wr_done_timing act=%0d exp=%0d", done_cyc, last_we + 1);
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_idle act=%b%b exp=01", busy, cmd_ready);
    end
  endtask

  // Read burst; mode 1 applies rd_ready pattern 1,0,0,1.
  task automatic do_read(input logic [ADDR_W-1:0] base, input int len, input int mode);
    logic [ADDR_W-1:0] a, a1, nxt, nxt1;
    logic [2*DATA_W-1:0] e;
    int issued = 0, popped = 0, cyc = 0, last_pop = -10, done_cyc = -1;
    bit fin = 1'b0;
    for (int k = 0; k < len; k++) begin
      a = base + ADDR_W'(2*k);
      a1 = a + 9'd1;
      rq.push_back({ref_mem[a], ref_mem[a1]});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_cmd_ready act=%b exp=1", cmd_ready); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = base; cmd_len = LEN_W'(len); rd_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || sram_raddr1 !== base) begin
      errors++; $display("FAIL rd_first_issue act=%b/%h exp=0/%h", rd_valid, sram_raddr1, base);
    end
    nxt = base;
    while (!fin && cyc < 300) begin
      if (done) begin
        fin = 1'b1;
        done_cyc = cyc;
      end else begin
        if (issued < len && sram_raddr1 === nxt) begin
          nxt1 = nxt + 9'd1;
          checks++;
          if (sram_raddr2 !== nxt1) begin errors++; $display("FAIL rd_addr2 act=%h exp=%h", sram_raddr2, nxt1); end
          issued++;
          nxt = nxt + 9'd2;
        end
        checks++;
        if (issued - popped > 2) begin
          errors++; $display("FAIL rd_outstanding act=%0d exp<=2", issued - popped);
        end
        rd_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        if (rd_valid && rd_ready) begin
          checks++;
          if (rq.size() == 0) begin
            errors++; $display("FAIL rd_extra_beat act=%h exp=none", {rd_data1, rd_data2});
          end else begin
            e = rq.pop_front();
            if ({rd_data1, rd_data2} !== e) begin
              errors++; $display("FAIL rd_data act=%h exp=%h", {rd_data1, rd_data2}, e);
            end
          end
          popped++;
          last_pop = cyc;
        end
        tick();
        cyc++;
      end
    end
    rd_ready = 1'b0;
    checks++;
    if (!fin) begin errors++; $display("FAIL rd_timeout act=no_done exp=done"); end
    checks++;
    if (popped != len || rq.size() != 0) begin
      errors++; $display("FAIL rd_count act=%0d exp=%0d left=%0d", popped, len, rq.size());
    end
    checks++;
    if (done_cyc != last_pop + 1) begin
      errors++; $display("FAIL rd_done_timing act=%0d exp=%0d", done_cyc, last_pop + 1);
    end
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL rd_idle act=%b%b exp=00", busy, rd_valid);
    end
  endtask

  task automatic test_write();
    do_write(9'h010, 2, 48'hA1A1_0000_0000);
  endtask

  task automatic test_back_to_back();
    do_read(9'h010, 2, 0);
  endtask

  task automatic test_backpressure();
    do_write(9'h100, 8, 48'hB0B0_0000_1000);
    do_read(9'h100, 8, 1);
  endtask

  task automatic test_boundary();
`ifdef V_SRAM_SEQ_WRAP_EN
    do_write(9'h1FE, 2, 48'hC0C0_0000_2000);
    do_read(9'h1FE, 2, 0);
`else
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 9'h1FE; cmd_len = 9'd2;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL overrange_err act=%b%b%b exp=101", err, busy, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (err !== 1'b0 || sram_we !== 1'b0 || wr_ready !== 1'b0) begin
        errors++; $display("FAIL overrange_quiet act=%b%b%b exp=000", err, sram_we, wr_ready);
      end
    end
`endif
    do_write(9'h1F0, 8, 48'hD0D0_0000_3000);
    do_read(9'h1F0, 8, 0);
  endtask

  task automatic test_null_odd();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 9'h020; cmd_len = 9'd0;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL null_done act=%b%b%b exp=100", done, busy, err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || rd_valid !== 1'b0 || sram_we !== 1'b0) begin
      errors++; $display("FAIL null_quiet act=%b%b%b exp=000", done, rd_valid, sram_we);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = 9'h011; cmd_len = 9'd2;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL odd_err act=%b%b%b%b exp=1010", err, busy, cmd_ready, done);
    end
    tick();
    checks++;
    if (err !== 1'b0 || wr_ready !== 1'b0 || sram_we !== 1'b0) begin
      errors++; $display("FAIL odd_quiet act=%b%b%b exp=000", err, wr_ready, sram_we);
    end
  endtask

  task automatic test_reset_mid();
    logic [2*DATA_W-1:0] e;
    int popped = 0, cyc = 0;
    do_write(9'h040, 8, 48'hE0E0_0000_4000);
    for (int k = 0; k < 8; k++) begin
      e = {ref_mem[9'h040 + 9'(2*k)], ref_mem[9'h041 + 9'(2*k)]};
      rq.push_back(e);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = 9'h040; cmd_len = 9'd8; rd_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    while (!(popped == 2 && rd_valid) && cyc < 50) begin
      if (rd_valid) begin
        e = rq.pop_front();
        checks++;
        if ({rd_data1, rd_data2} !== e) begin
          errors++; $display("FAIL mid_data act=%h exp=%h", {rd_data1, rd_data2}, e);
        end
        popped++;
      end
      tick();
      cyc++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rd_valid, sram_we, busy, cmd_ready, done} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_status act=%b exp=00000", {rd_valid, sram_we, busy, cmd_ready, done});
    end
    checks++;
    if ({rd_data1, rd_data2, sram_raddr1, sram_raddr2} !== {(2*DATA_W + 2*ADDR_W){1'b0}}) begin
      errors++; $display("FAIL mid_reset_outputs act=%h exp=0", {rd_data1, rd_data2, sram_raddr1, sram_raddr2});
    end
    rq.delete();
    rd_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || rd_valid !== 1'b0) begin
        errors++; $display("FAIL mid_after act=%b%b exp=00", done, rd_valid);
      end
    end
    do_read(9'h040, 2, 0);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = 9'h000; cmd_len = 9'd0;
    wr_valid = 1'b0; wr_data1 = 48'h0; wr_data2 = 48'h0; rd_ready = 1'b0;
    for (int i = 0; i < 512; i++) begin
      sram_mem[i] = 48'h0;
      ref_mem[i]  = 48'h0;
    end
    test_reset();
    test_write();
    test_back_to_back();
    test_backpressure();
    test_boundary();
    test_null_odd();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/v_sram_op2_seq.md
# v_sram_op2_seq

Burst access sequencer that drives the dual-read/dual-write 48-bit, 512-entry operand SRAM (`v_sram_op2`) from the vector datapath side. It accepts read or write burst commands, generates paired word addresses (a, a+1) for both SRAM ports, streams write data in, and returns read data on a valid/ready stream with 2-entry buffering. It is the initiator for every SRAM access and enforces write-commit-before-read ordering between bursts.

## Interface
Parameters:
- `ADDR_W`, 9: SRAM word address width.
- `DATA_W`, 48: SRAM word width.
- `LEN_W`, 9: burst length field width, counted in word pairs.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_base` in ADDR_W: first word address; must be even.
- `cmd_len` in LEN_W: burst length in pairs, 1..256; 0 is a null command.
- `wr_valid` in 1 / `wr_ready` out 1: write-beat handshake.
- `wr_data1`, `wr_data2` in DATA_W: words for addresses a and a+1.
- `rd_valid` out 1 / `rd_ready` in 1: read-beat handshake.
- `rd_data1`, `rd_data2` out DATA_W: words from addresses a and a+1.
- `sram_we` out 1, `sram_waddr1`, `sram_waddr2` out ADDR_W, `sram_wdata1`, `sram_wdata2` out DATA_W: registered SRAM write drive.
- `sram_raddr1`, `sram_raddr2` out ADDR_W: registered SRAM read addresses.
- `sram_rdata1`, `sram_rdata2` in DATA_W: SRAM read buses, valid before the edge after the address.
- `busy` out 1, `done` out 1, `err` out 1: status; `done` and `err` are 1-cycle pulses.

## Operation
- States: IDLE, WRITE, READ. `cmd_ready` = (state == IDLE) and not reset.
- Reset values: state IDLE, every SRAM output 0, `sram_we` 0, `rd_valid`/`wr_ready`/`done`/`err`/`busy` 0, buffer empty, counters 0.
- Command accept, len == 0: stays in IDLE and pulses `done` next cycle. No SRAM activity.
- Command with odd `cmd_base`: rejected; `err` pulses next cycle. No state change.
- Address arithmetic: pair k uses a = base + 2k and a+1, both modulo 2^ADDR_W (see Configuration).
- WRITE: `wr_ready` = 1 while beats remain. Each accepted beat registers `sram_we`=1, the addresses and both data words. `sram_we` drops at the next edge unless another beat is accepted. After the last beat, the state returns to IDLE at the following edge and `done` pulses then.
- READ: an address pair is issued at an edge only if outstanding (in flight + buffered − popping this edge) < 2. Data is captured from `sram_rdata*` at the edge after issue into a 2-entry FIFO. `rd_valid` = FIFO non-empty. `done` pulses the cycle after the last beat is popped, when the state returns to IDLE.
- `busy` = state != IDLE.

## Timing
- Write: beat accepted at edge E, SRAM commits at E+1, `done` high during E+1..E+2, and `cmd_ready` high from E+1. A read accepted at E+1 sees the written data.
- Read: command accepted at edge E0 registers pair 0 addresses. Pair 0 is captured at E1, so `rd_valid` is high from E1. Sustained rate is 1 pair/cycle while `rd_ready`=1.
- Backpressure: with `rd_ready`=0, at most 2 pairs are buffered and issue stalls. Data is never dropped or duplicated.
- Mid-burst `reset`: the burst aborts, the FIFO is flushed and `sram_we` deasserts asynchronously. No `done` pulse.

## Configuration
- `V_SRAM_SEQ_WRAP_EN` defined: burst addresses wrap modulo 512. base=510, len=2 accesses 510,511,0,1.
- Undefined: a command with base + 2·len > 512 is rejected at accept with an `err` pulse and no access. Exactly 512 is legal.

## Test plan
- Write base=0x010, len=2 with data {A1,A2},{B1,B2} → `sram_we` high 2 cycles, waddr 0x010/0x011 then 0x012/0x013. `done` pulses 1 cycle after the last commit.
- Back-to-back: read base=0x010, len=2 issued on the `done` cycle → `rd_data` = {A1,A2} then {B1,B2}, `rd_valid` one cycle after accept.
- Read len=8 with `rd_ready` toggled 1,0,0,1… → exactly 8 beats, in order, at most 2 outstanding, no loss.
- base=0x1FE, len=2 → with the macro defined: addresses 0x1FE/0x1FF then 0x000/0x001. Without the macro: `err` pulse and no SRAM activity.
- len=0 → `done` next cycle, no access. Odd base=0x011 → `err`, state stays IDLE.
- Assert `reset` during beat 3 of a len=8 read → outputs zero immediately. The next command behaves normally.
